// File: rtl/mem_if_pkg.sv
// Shared widths, FSM state type and beat-slicing helpers for the backup-memory
// line port.
package mem_if_pkg;

  localparam int unsigned MEM_ADDR_BITS  = 28;
  localparam int unsigned MEM_DATA_BITS  = 128;
  localparam int unsigned MEM_TAG_BITS   = 5;
  localparam int unsigned BEATS          = 4;
  localparam int unsigned MEM_MASK_BITS  = MEM_DATA_BITS / 8;
  localparam int unsigned LINE_BITS      = BEATS * MEM_DATA_BITS;
  localparam int unsigned LINE_MASK_BITS = BEATS * MEM_MASK_BITS;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WDATA,
    RDATA,
    DONE
  } state_e;

  function automatic logic [MEM_DATA_BITS-1:0] beat_data(
    input logic [LINE_BITS-1:0] line,
    input logic [1:0]           idx
  );
    return line[int'(idx)*MEM_DATA_BITS +: MEM_DATA_BITS];
  endfunction

  function automatic logic [MEM_MASK_BITS-1:0] beat_mask(
    input logic [LINE_MASK_BITS-1:0] mask,
    input logic [1:0]                idx
  );
    return mask[int'(idx)*MEM_MASK_BITS +: MEM_MASK_BITS];
  endfunction

endpackage

// File: rtl/mem_line_port.sv
// Cache-line initiator: turns one line read/write into a tagged memory command
// plus four data or response beats, then a single completion pulse.
module mem_line_port
  import mem_if_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_rw,
  input  logic [MEM_ADDR_BITS-1:0]  req_addr,
  input  logic [LINE_BITS-1:0]      req_wdata,
  input  logic [LINE_MASK_BITS-1:0] req_wmask,
  output logic                      resp_valid,
  output logic                      resp_rw,
  output logic [LINE_BITS-1:0]      resp_data,
  output logic                      err,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_rw,
  output logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
  output logic [MEM_TAG_BITS-1:0]   mem_req_tag,
  output logic                      mem_req_data_valid,
  input  logic                      mem_req_data_ready,
  output logic [MEM_DATA_BITS-1:0]  mem_req_data_bits,
  output logic [MEM_MASK_BITS-1:0]  mem_req_data_mask,
  output logic [1:0]                mem_req_data_offset,
  input  logic                      mem_resp_valid,
  input  logic [MEM_TAG_BITS-1:0]   mem_resp_tag,
  input  logic [MEM_DATA_BITS-1:0]  mem_resp_data
);

  state_e                    state_q, state_d;
  logic                      rw_q, rw_d;
  logic [MEM_ADDR_BITS-1:0]  addr_q, addr_d;
  logic [LINE_BITS-1:0]      wdata_q, wdata_d;
  logic [LINE_MASK_BITS-1:0] wmask_q, wmask_d;
  logic [MEM_TAG_BITS-1:0]   tag_q, tag_d;
  logic [MEM_TAG_BITS-1:0]   tag_cnt_q, tag_cnt_d;
  logic [1:0]                cnt_q, cnt_d;
  logic [LINE_BITS-1:0]      rbuf_q, rbuf_d;
  logic [LINE_BITS-1:0]      resp_data_q, resp_data_d;
  logic                      err_q, err_d;
  logic                      beat_hit;

  assign beat_hit = (state_q == RDATA) && mem_resp_valid && (mem_resp_tag == tag_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = CMD;
      CMD:     if (mem_req_ready) state_d = rw_q ? WDATA : RDATA;
      WDATA:   if (mem_req_data_ready && (cnt_q == 2'd3)) state_d = DONE;
      RDATA:   if (beat_hit && (cnt_q == 2'd3)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reads assemble in rbuf so resp_data only changes when a whole line lands.
  always_comb begin
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    tag_d       = tag_q;
    tag_cnt_d   = tag_cnt_q;
    cnt_d       = cnt_q;
    rbuf_d      = rbuf_q;
    resp_data_d = resp_data_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rw_d      = req_rw;
          addr_d    = req_addr & ~MEM_ADDR_BITS'(3);
          wdata_d   = req_wdata;
          wmask_d   = req_wmask;
          tag_d     = tag_cnt_q;
          tag_cnt_d = tag_cnt_q + 1'b1;
        end
      end
      CMD: begin
        if (mem_req_ready) cnt_d = '0;
      end
      WDATA: begin
        if (mem_req_data_ready) cnt_d = cnt_q + 2'd1;
      end
      RDATA: begin
        if (beat_hit) begin
          rbuf_d[int'(cnt_q)*MEM_DATA_BITS +: MEM_DATA_BITS] = mem_resp_data;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) resp_data_d = rbuf_d;
        end
      end
      default: ;
    endcase
    if (mem_resp_valid && !beat_hit) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      tag_q       <= '0;
      tag_cnt_q   <= '0;
      cnt_q       <= '0;
      rbuf_q      <= '0;
      resp_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      tag_q       <= tag_d;
      tag_cnt_q   <= tag_cnt_d;
      cnt_q       <= cnt_d;
      rbuf_q      <= rbuf_d;
      resp_data_q <= resp_data_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    req_ready           = (state_q == IDLE);
    mem_req_valid       = (state_q == CMD);
    mem_req_data_valid  = (state_q == WDATA);
    resp_valid          = (state_q == DONE);
    resp_rw             = rw_q;
    resp_data           = resp_data_q;
    err                 = err_q;
    mem_req_rw          = rw_q;
    mem_req_addr        = addr_q;
    mem_req_tag         = tag_q;
    mem_req_data_bits   = beat_data(wdata_q, cnt_q);
    mem_req_data_mask   = beat_mask(wmask_q, cnt_q);
    mem_req_data_offset = cnt_q;
  end

endmodule
